// File: rtl/exotiny_mem_arb_if.sv
// rtl/exotiny_mem_arb_if.sv - bus bundle between requesters, arbiter and memory port
//
// Purpose: groups the imem/dmem Wishbone-classic requester signals, the shared
// memory port and the watchdog pulse so they travel as one port.
// Ports (signal groups):
//   imem_*  fetch requester: stb/adr in, rdat/ack out
//   dmem_*  data requester: stb/we/be/adr/wdat in, rdat/ack out
//   mem_*   shared memory port: cyc/stb/we/be/adr/wdat out, rdat/ack in
//   tmo_o   watchdog termination pulse
// Modports:
//   slave   the arbiter's view
//   master  the environment's view (core requesters plus memory)
interface exotiny_mem_arb_if #(
  parameter int ADR_W = 24
);
  logic             imem_stb_i;
  logic [ADR_W-1:0] imem_adr_i;
  logic [31:0]      imem_rdat_o;
  logic             imem_ack_o;

  logic             dmem_stb_i;
  logic             dmem_we_i;
  logic [3:0]       dmem_be_i;
  logic [ADR_W-1:0] dmem_adr_i;
  logic [31:0]      dmem_wdat_i;
  logic [31:0]      dmem_rdat_o;
  logic             dmem_ack_o;

  logic             mem_cyc_o;
  logic             mem_stb_o;
  logic             mem_we_o;
  logic [3:0]       mem_be_o;
  logic [ADR_W-1:0] mem_adr_o;
  logic [31:0]      mem_wdat_o;
  logic [31:0]      mem_rdat_i;
  logic             mem_ack_i;

  logic             tmo_o;

  modport slave (
    input  imem_stb_i, imem_adr_i,
    output imem_rdat_o, imem_ack_o,
    input  dmem_stb_i, dmem_we_i, dmem_be_i, dmem_adr_i, dmem_wdat_i,
    output dmem_rdat_o, dmem_ack_o,
    output mem_cyc_o, mem_stb_o, mem_we_o, mem_be_o, mem_adr_o, mem_wdat_o,
    input  mem_rdat_i, mem_ack_i,
    output tmo_o
  );

  modport master (
    output imem_stb_i, imem_adr_i,
    input  imem_rdat_o, imem_ack_o,
    output dmem_stb_i, dmem_we_i, dmem_be_i, dmem_adr_i, dmem_wdat_i,
    input  dmem_rdat_o, dmem_ack_o,
    input  mem_cyc_o, mem_stb_o, mem_we_o, mem_be_o, mem_adr_o, mem_wdat_o,
    output mem_rdat_i, mem_ack_i,
    input  tmo_o
  );
endinterface

// File: rtl/exotiny_mem_arb.sv
// rtl/exotiny_mem_arb.sv - two-requester round-robin arbiter with watchdog for the exotiny memory port
//
// Purpose: shares one Wishbone-classic memory port between FazyRV instruction
// fetch (imem) and data access (dmem). Ties go to the requester not served last;
// the grant is held until the memory acks or the watchdog terminates the transfer.
// Ports:
//   clk_i   clock
//   rst_in  asynchronous active-low reset
//   bus     exotiny_mem_arb_if.slave: imem/dmem requester sides, memory port, tmo_o
// Parameters:
//   ADR_W    address width on all ports
//   TMO_CYC  cycles a granted transfer may wait for mem_ack_i (0 = no watchdog)
//   TMO_DAT  read data handed back when the watchdog fires
module exotiny_mem_arb #(
  parameter int          ADR_W   = 24,
  parameter int          TMO_CYC = 255,
  parameter logic [31:0] TMO_DAT = 32'hDEAD_BEEF
) (
  input  logic                clk_i,
  input  logic                rst_in,
  exotiny_mem_arb_if.slave    bus
);

  localparam int CNT_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t           state_q;
  logic             last_q;      // 1 = dmem was granted most recently
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             mem_stb_q;
  logic             mem_we_q;
  logic [3:0]       mem_be_q;
  logic [ADR_W-1:0] mem_adr_q;
  logic [31:0]      mem_wdat_q;

  logic ack_in;
  logic tmo_hit;
  logic done;
  logic pick_d;

  // A memory ack only counts while our strobe is out; stray acks in IDLE vanish here.
  assign ack_in  = bus.mem_ack_i & mem_stb_q;
  // A real ack in the last watchdog cycle wins over the timeout.
  assign tmo_hit = (TMO_CYC > 0) && (state_q != IDLE) && (tmo_cnt_q == TMO_LAST) && !ack_in;
  assign done    = ack_in | tmo_hit;
  // dmem wins when it is alone, or on a tie when imem was served last.
  assign pick_d  = bus.dmem_stb_i & (~bus.imem_stb_i | ~last_q);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      tmo_cnt_q  <= '0;
      mem_stb_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 4'h0;
      mem_adr_q  <= '0;
      mem_wdat_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.imem_stb_i || bus.dmem_stb_i) begin
            state_q    <= pick_d ? GNT_D : GNT_I;
            last_q     <= pick_d;
            tmo_cnt_q  <= '0;
            mem_stb_q  <= 1'b1;
            mem_we_q   <= pick_d & bus.dmem_we_i;
            mem_be_q   <= pick_d ? bus.dmem_be_i : 4'hF;
            mem_adr_q  <= pick_d ? bus.dmem_adr_i : bus.imem_adr_i;
            mem_wdat_q <= pick_d ? bus.dmem_wdat_i : 32'h0;
          end
        end
        GNT_I, GNT_D: begin
          if (done) begin
            state_q   <= IDLE;
            mem_stb_q <= 1'b0;
          end else if (TMO_CYC > 0) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_stb_q <= 1'b0;
        end
      endcase
    end
  end

  // Requester responses are a pass-through of the memory port while granted,
  // so a zero-wait memory completes in the same cycle its strobe is seen.
  always_comb begin
    bus.imem_ack_o  = 1'b0;
    bus.imem_rdat_o = 32'h0;
    bus.dmem_ack_o  = 1'b0;
    bus.dmem_rdat_o = 32'h0;
    if (state_q == GNT_I) begin
      bus.imem_ack_o  = done;
      bus.imem_rdat_o = tmo_hit ? TMO_DAT : bus.mem_rdat_i;
    end else if (state_q == GNT_D) begin
      bus.dmem_ack_o  = done;
      bus.dmem_rdat_o = tmo_hit ? TMO_DAT : bus.mem_rdat_i;
    end
  end

  assign bus.tmo_o      = tmo_hit;
  assign bus.mem_cyc_o  = mem_stb_q;
  assign bus.mem_stb_o  = mem_stb_q;
  assign bus.mem_we_o   = mem_we_q;
  assign bus.mem_be_o   = mem_be_q;
  assign bus.mem_adr_o  = mem_adr_q;
  assign bus.mem_wdat_o = mem_wdat_q;

endmodule

// File: tb/tb_exotiny_mem_arb.sv
// tb/tb_exotiny_mem_arb.sv - self-checking bench for exotiny_mem_arb
module tb_exotiny_mem_arb;
  localparam int          ADR_W   = 24;
  localparam int          TMO_CYC = 8;
  localparam logic [31:0] TMO_DAT = 32'hDEAD_BEEF;

  logic clk_i = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_i = ~clk_i;

  exotiny_mem_arb_if #(.ADR_W(ADR_W)) bus ();

  exotiny_mem_arb #(.ADR_W(ADR_W), .TMO_CYC(TMO_CYC), .TMO_DAT(TMO_DAT)) dut (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // memory responder controls
  int wait_cnt = 0;
  int mem_lat  = 0;
  bit ack_en   = 1'b1;
  bit lat_rand = 1'b0;
  bit idle_ack = 1'b0;

  function automatic logic [31:0] memval(logic [ADR_W-1:0] a);
    return {a[7:0], a} ^ 32'h0000_0113;
  endfunction

  task automatic clear_reqs();
    bus.imem_stb_i  = 1'b0;
    bus.imem_adr_i  = '0;
    bus.dmem_stb_i  = 1'b0;
    bus.dmem_we_i   = 1'b0;
    bus.dmem_be_i   = 4'h0;
    bus.dmem_adr_i  = '0;
    bus.dmem_wdat_i = 32'h0;
  endtask

  // One clock: outputs sampled at +1, memory responds from the registered
  // strobe, combinational requester responses sampled at +2.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (bus.mem_stb_o === 1'b1) begin
      if (wait_cnt == 0 && lat_rand) mem_lat = $urandom_range(0, 4);
      bus.mem_ack_i  = ack_en && (wait_cnt == mem_lat);
      bus.mem_rdat_i = memval(bus.mem_adr_o);
      wait_cnt++;
    end else begin
      bus.mem_ack_i  = idle_ack;
      bus.mem_rdat_i = 32'h5A5A_5A5A;
      wait_cnt = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    clear_reqs();
    ack_en = 1'b1; lat_rand = 1'b0; idle_ack = 1'b0; mem_lat = 0;
    bus.mem_ack_i = 1'b0; bus.mem_rdat_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #2;
    rst_in = 1'b1;
    wait_cnt = 0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    clear_reqs();
    bus.imem_stb_i = 1'b1; bus.dmem_stb_i = 1'b1;
    bus.mem_ack_i = 1'b1; bus.mem_rdat_i = 32'h1234_5678;
    repeat (2) @(posedge clk_i);
    #1;
    n_vec++;
    if ({bus.mem_cyc_o, bus.mem_stb_o} !== 2'b00) begin
      n_err++; $display("FAIL reset_stb: got %b, expected 00", {bus.mem_cyc_o, bus.mem_stb_o});
    end
    n_vec++;
    if ({bus.mem_we_o, bus.mem_be_o, bus.mem_adr_o, bus.mem_wdat_o} !== '0) begin
      n_err++; $display("FAIL reset_fields: got we=%b be=%h adr=%h wdat=%h, expected all 0",
                        bus.mem_we_o, bus.mem_be_o, bus.mem_adr_o, bus.mem_wdat_o);
    end
    n_vec++;
    if ({bus.imem_ack_o, bus.dmem_ack_o, bus.tmo_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_acks: got %b, expected 000", {bus.imem_ack_o, bus.dmem_ack_o, bus.tmo_o});
    end
    n_vec++;
    if ({bus.imem_rdat_o, bus.dmem_rdat_o} !== 64'h0) begin
      n_err++; $display("FAIL reset_rdat: got %h/%h, expected 0/0", bus.imem_rdat_o, bus.dmem_rdat_o);
    end
    clear_reqs();
    bus.mem_ack_i = 1'b0;
    rst_in = 1'b1;
  endtask

  task automatic test_imem_fetch();
    do_reset();
    mem_lat = 2;
    bus.imem_stb_i = 1'b1; bus.imem_adr_i = 24'h000100;
    step();
    n_vec++;
    if ({bus.mem_cyc_o, bus.mem_stb_o, bus.mem_we_o, bus.mem_be_o, bus.mem_adr_o} !== {3'b110, 4'hF, 24'h000100}) begin
      n_err++; $display("FAIL fetch_grant: got cyc=%b stb=%b we=%b be=%h adr=%h, expected 1 1 0 f 000100",
                        bus.mem_cyc_o, bus.mem_stb_o, bus.mem_we_o, bus.mem_be_o, bus.mem_adr_o);
    end
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (bus.imem_ack_o !== 1'b0) begin
        n_err++; $display("FAIL fetch_early_ack: cycle %0d got %b, expected 0", k, bus.imem_ack_o);
      end
      step();
    end
    n_vec++;
    if ({bus.imem_ack_o, bus.dmem_ack_o, bus.imem_rdat_o} !== {2'b10, 32'h0000_0013}) begin
      n_err++; $display("FAIL fetch_ack: got ack=%b/%b rdat=%h, expected 1/0 00000013",
                        bus.imem_ack_o, bus.dmem_ack_o, bus.imem_rdat_o);
    end
    bus.imem_stb_i = 1'b0;
    step();
    n_vec++;
    if ({bus.mem_stb_o, bus.imem_ack_o} !== 2'b00) begin
      n_err++; $display("FAIL fetch_release: got stb/ack %b, expected 00", {bus.mem_stb_o, bus.imem_ack_o});
    end
  endtask

  task automatic test_tie_alternation();
    int order[$];
    do_reset();
    mem_lat = 0;
    bus.imem_stb_i = 1'b1; bus.imem_adr_i = 24'h000200;
    bus.dmem_stb_i = 1'b1; bus.dmem_adr_i = 24'h000300; bus.dmem_be_i = 4'hF;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      step();
      n_vec++;
      if (bus.imem_ack_o === 1'b1 && bus.dmem_ack_o === 1'b1) begin
        n_err++; $display("FAIL tie_double_ack: got both acks, expected one");
      end
      if (bus.imem_ack_o === 1'b1) order.push_back(0);
      else if (bus.dmem_ack_o === 1'b1) order.push_back(1);
    end
    n_vec++;
    if (order.size() != 4) begin
      n_err++; $display("FAIL tie_count: got %0d transfers, expected 4", order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (order[k] != (k % 2)) begin
          n_err++; $display("FAIL tie_order: transfer %0d got %s, expected %s",
                            k, order[k] ? "D" : "I", (k % 2) ? "D" : "I");
        end
      end
    end
    clear_reqs();
    step();
  endtask

  task automatic test_dmem_write();
    do_reset();
    mem_lat = 0;
    bus.dmem_stb_i = 1'b1; bus.dmem_we_i = 1'b1; bus.dmem_be_i = 4'b0001;
    bus.dmem_adr_i = 24'h00000C; bus.dmem_wdat_i = 32'h44;
    step();
    n_vec++;
    if ({bus.mem_we_o, bus.mem_be_o, bus.mem_adr_o, bus.mem_wdat_o} !== {1'b1, 4'b0001, 24'h00000C, 32'h44}) begin
      n_err++; $display("FAIL write_fields: got we=%b be=%b adr=%h wdat=%h, expected 1 0001 00000c 00000044",
                        bus.mem_we_o, bus.mem_be_o, bus.mem_adr_o, bus.mem_wdat_o);
    end
    n_vec++;
    if ({bus.dmem_ack_o, bus.imem_ack_o} !== 2'b10) begin
      n_err++; $display("FAIL write_ack: got d/i %b, expected 10", {bus.dmem_ack_o, bus.imem_ack_o});
    end
    clear_reqs();
    step();
    n_vec++;
    if ({bus.mem_stb_o, bus.dmem_ack_o, bus.imem_ack_o} !== 3'b000) begin
      n_err++; $display("FAIL write_single_pulse: got %b, expected 000", {bus.mem_stb_o, bus.dmem_ack_o, bus.imem_ack_o});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ack_en = 1'b0;
    bus.dmem_stb_i = 1'b1; bus.dmem_adr_i = 24'h000040; bus.dmem_be_i = 4'hF;
    for (int k = 0; k < TMO_CYC; k++) begin
      step();
      if (k < TMO_CYC - 1) begin
        n_vec++;
        if ({bus.mem_stb_o, bus.dmem_ack_o, bus.tmo_o} !== 3'b100) begin
          n_err++; $display("FAIL tmo_wait: cycle %0d got stb/ack/tmo %b, expected 100",
                            k, {bus.mem_stb_o, bus.dmem_ack_o, bus.tmo_o});
        end
      end
    end
    n_vec++;
    if ({bus.dmem_ack_o, bus.imem_ack_o, bus.tmo_o, bus.dmem_rdat_o} !== {3'b101, TMO_DAT}) begin
      n_err++; $display("FAIL tmo_fire: got ack=%b/%b tmo=%b rdat=%h, expected 1/0 1 %h",
                        bus.dmem_ack_o, bus.imem_ack_o, bus.tmo_o, bus.dmem_rdat_o, TMO_DAT);
    end
    clear_reqs();
    ack_en = 1'b1;
    step();
    n_vec++;
    if ({bus.mem_stb_o, bus.tmo_o, bus.dmem_ack_o} !== 3'b000) begin
      n_err++; $display("FAIL tmo_after: got %b, expected 000", {bus.mem_stb_o, bus.tmo_o, bus.dmem_ack_o});
    end
    mem_lat = 1;
    bus.imem_stb_i = 1'b1; bus.imem_adr_i = 24'h000080;
    step();
    step();
    n_vec++;
    if ({bus.imem_ack_o, bus.tmo_o, bus.imem_rdat_o} !== {2'b10, memval(24'h000080)}) begin
      n_err++; $display("FAIL tmo_recover: got ack=%b tmo=%b rdat=%h, expected 1 0 %h",
                        bus.imem_ack_o, bus.tmo_o, bus.imem_rdat_o, memval(24'h000080));
    end
    clear_reqs();
    step();
  endtask

  task automatic test_ack_with_tmo();
    do_reset();
    mem_lat = TMO_CYC - 1;
    bus.dmem_stb_i = 1'b1; bus.dmem_adr_i = 24'h000024; bus.dmem_be_i = 4'hF;
    for (int k = 0; k < TMO_CYC - 1; k++) begin
      step();
      n_vec++;
      if (bus.dmem_ack_o !== 1'b0) begin
        n_err++; $display("FAIL race_early_ack: cycle %0d got %b, expected 0", k, bus.dmem_ack_o);
      end
    end
    step();
    n_vec++;
    if ({bus.dmem_ack_o, bus.tmo_o, bus.dmem_rdat_o} !== {2'b10, memval(24'h000024)}) begin
      n_err++; $display("FAIL race_ack_wins: got ack=%b tmo=%b rdat=%h, expected 1 0 %h",
                        bus.dmem_ack_o, bus.tmo_o, bus.dmem_rdat_o, memval(24'h000024));
    end
    clear_reqs();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ack_en = 1'b0;
    bus.dmem_stb_i = 1'b1; bus.dmem_adr_i = 24'h000050; bus.dmem_be_i = 4'hF;
    step();
    step();
    rst_in = 1'b0;
    #1;
    n_vec++;
    if ({bus.mem_cyc_o, bus.mem_stb_o, bus.dmem_ack_o, bus.tmo_o} !== 4'b0000) begin
      n_err++; $display("FAIL rst_abort: got cyc/stb/ack/tmo %b, expected 0000",
                        {bus.mem_cyc_o, bus.mem_stb_o, bus.dmem_ack_o, bus.tmo_o});
    end
    step();
    n_vec++;
    if ({bus.dmem_ack_o, bus.imem_ack_o} !== 2'b00) begin
      n_err++; $display("FAIL rst_no_ack: got %b, expected 00", {bus.dmem_ack_o, bus.imem_ack_o});
    end
    clear_reqs();
    ack_en = 1'b1; mem_lat = 0;
    rst_in = 1'b1;
    bus.imem_stb_i = 1'b1; bus.imem_adr_i = 24'h000060;
    bus.dmem_stb_i = 1'b1; bus.dmem_adr_i = 24'h000070; bus.dmem_be_i = 4'hF;
    step();
    n_vec++;
    if ({bus.mem_adr_o, bus.imem_ack_o, bus.dmem_ack_o} !== {24'h000060, 2'b10}) begin
      n_err++; $display("FAIL rst_first_tie: got adr=%h ack=%b/%b, expected 000060 1/0",
                        bus.mem_adr_o, bus.imem_ack_o, bus.dmem_ack_o);
    end
    bus.imem_stb_i = 1'b0;
    step();
    step();
    n_vec++;
    if ({bus.mem_adr_o, bus.dmem_ack_o} !== {24'h000070, 1'b1}) begin
      n_err++; $display("FAIL rst_second: got adr=%h ack=%b, expected 000070 1", bus.mem_adr_o, bus.dmem_ack_o);
    end
    clear_reqs();
    step();
  endtask

  task automatic test_idle_ack();
    do_reset();
    idle_ack = 1'b1;
    step();
    n_vec++;
    if ({bus.imem_ack_o, bus.dmem_ack_o, bus.tmo_o, bus.imem_rdat_o, bus.dmem_rdat_o} !== 67'h0) begin
      n_err++; $display("FAIL idle_ack_ignored: got ack=%b/%b rdat=%h/%h, expected 0/0 0/0",
                        bus.imem_ack_o, bus.dmem_ack_o, bus.imem_rdat_o, bus.dmem_rdat_o);
    end
    idle_ack = 1'b0;
    step();
    n_vec++;
    if (bus.mem_stb_o !== 1'b0) begin
      n_err++; $display("FAIL idle_ack_state: got mem_stb_o %b, expected 0", bus.mem_stb_o);
    end
    bus.imem_stb_i = 1'b1; bus.imem_adr_i = 24'h0000A0;
    step();
    n_vec++;
    if ({bus.mem_stb_o, bus.imem_ack_o, bus.imem_rdat_o} !== {2'b11, memval(24'h0000A0)}) begin
      n_err++; $display("FAIL idle_ack_then_req: got stb=%b ack=%b rdat=%h, expected 1 1 %h",
                        bus.mem_stb_o, bus.imem_ack_o, bus.imem_rdat_o, memval(24'h0000A0));
    end
    clear_reqs();
    step();
  endtask

  // Random traffic: reference model tracks pending requests per requester,
  // who was served last, and when the port is free to grant again.
  task automatic test_random();
    bit pend_i = 0, pend_d = 0, busy = 0, cur = 0, last_g = 1, who, drv_i, drv_d;
    int free_cyc = 0, age_i = 0, age_d = 0, done_i = 0, done_d = 0;
    logic [ADR_W-1:0] ia = '0, da = '0;
    logic dwe = 0;
    logic [3:0] dbe = 4'h0;
    logic [31:0] dwd = 32'h0;
    do_reset();
    lat_rand = 1'b1;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      drv_i = pend_i; drv_d = pend_d;
      step();
      if (!busy) begin
        n_vec++;
        if (cyc >= free_cyc && (drv_i || drv_d)) begin
          who = (drv_i && drv_d) ? !last_g : drv_d;
          if ({bus.mem_stb_o, bus.mem_we_o, bus.mem_be_o, bus.mem_adr_o} !==
              {1'b1, who ? dwe : 1'b0, who ? dbe : 4'hF, who ? da : ia} ||
              (who && bus.mem_wdat_o !== dwd)) begin
            n_err++; $display("FAIL rnd_grant: cyc %0d got stb=%b we=%b be=%h adr=%h, expected %s grant adr=%h",
                              cyc, bus.mem_stb_o, bus.mem_we_o, bus.mem_be_o, bus.mem_adr_o,
                              who ? "D" : "I", who ? da : ia);
          end
          busy = 1; cur = who; last_g = who;
        end else if (bus.mem_stb_o !== 1'b0) begin
          n_err++; $display("FAIL rnd_idle_stb: cyc %0d got %b, expected 0", cyc, bus.mem_stb_o);
        end
      end
      n_vec++;
      if (busy && bus.mem_ack_i === 1'b1) begin
        if ({bus.imem_ack_o, bus.dmem_ack_o, bus.tmo_o} !== (cur ? 3'b010 : 3'b100) ||
            (cur ? bus.dmem_rdat_o : bus.imem_rdat_o) !== memval(cur ? da : ia) ||
            (cur ? bus.imem_rdat_o : bus.dmem_rdat_o) !== 32'h0) begin
          n_err++; $display("FAIL rnd_ack: cyc %0d got ack=%b/%b tmo=%b rdat=%h/%h, expected %s ack data %h",
                            cyc, bus.imem_ack_o, bus.dmem_ack_o, bus.tmo_o, bus.imem_rdat_o,
                            bus.dmem_rdat_o, cur ? "D" : "I", memval(cur ? da : ia));
        end
        busy = 0; free_cyc = cyc + 2;
        if (cur) begin pend_d = 0; done_d++; end
        else begin pend_i = 0; done_i++; end
      end else if ({bus.imem_ack_o, bus.dmem_ack_o, bus.tmo_o} !== 3'b000) begin
        n_err++; $display("FAIL rnd_spurious_ack: cyc %0d got %b, expected 000",
                          cyc, {bus.imem_ack_o, bus.dmem_ack_o, bus.tmo_o});
      end
      if (!pend_i && $urandom_range(0, 2) != 0) begin
        pend_i = 1; age_i = 0; ia = ADR_W'($urandom);
      end
      if (!pend_d && $urandom_range(0, 2) != 0) begin
        pend_d = 1; age_d = 0; da = ADR_W'($urandom);
        dwe = 1'($urandom); dbe = 4'($urandom); dwd = $urandom;
      end
      bus.imem_stb_i = pend_i; bus.imem_adr_i = ia;
      bus.dmem_stb_i = pend_d; bus.dmem_adr_i = da;
      bus.dmem_we_i = dwe; bus.dmem_be_i = dbe; bus.dmem_wdat_i = dwd;
      if (pend_i) age_i++;
      if (pend_d) age_d++;
      if (age_i > 40 || age_d > 40) begin
        n_vec++; n_err++;
        $display("FAIL rnd_stall: cyc %0d request age i=%0d d=%0d, required <= 40", cyc, age_i, age_d);
        break;
      end
    end
    n_vec++;
    if (done_i < 20 || done_d < 20) begin
      n_err++; $display("FAIL rnd_progress: got %0d/%0d transfers, required >= 20 each", done_i, done_d);
    end
    clear_reqs();
    lat_rand = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_imem_fetch();
    test_tie_alternation();
    test_dmem_write();
    test_timeout();
    test_ack_with_tmo();
    test_reset_mid();
    test_idle_ack();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded 1 ms, expected to finish earlier");
    $fatal(1);
  end

endmodule
